// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - opcodes, flag indices, FSM states and PSR update masks
package alu_sequencer_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_CMP  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_NOT  = 5'd6;
  localparam logic [4:0] OP_LSH  = 5'd7;
  localparam logic [4:0] OP_RSH  = 5'd8;
  localparam logic [4:0] OP_ARSH = 5'd9;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
  } seq_state_t;

  function automatic logic op_legal(input logic [4:0] op);
    return op <= OP_ARSH;
  endfunction

  // Bits set here are the PSR bits an opcode is allowed to overwrite.
  function automatic logic [4:0] psr_mask(input logic [4:0] op);
    logic [4:0] m;
    m = 5'b00000;
    case (op)
      OP_ADD, OP_SUB: m = 5'b11111;
      OP_CMP: begin
        m[FLAG_L] = 1'b1;
        m[FLAG_Z] = 1'b1;
        m[FLAG_N] = 1'b1;
      end
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_sequencer_alu.sv
// rtl/alu_sequencer_alu.sv - combinational 16-bit ALU with comparison/carry/overflow flags
module alu_sequencer_alu
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        op,
  output logic [DATA_W-1:0] out,
  output logic [4:0]        flags
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;

  always_comb begin
    out   = '0;
    flags = 5'b00000;
    case (op)
      OP_ADD:  out = sum[DATA_W-1:0];
      OP_SUB:  out = diff;
      OP_CMP:  out = diff;
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_XOR:  out = a ^ b;
      OP_NOT:  out = ~b;
      OP_LSH:  out = {b[DATA_W-2:0], 1'b0};
      OP_RSH:  out = {1'b0, b[DATA_W-1:1]};
      OP_ARSH: out = {b[DATA_W-1], b[DATA_W-1:1]};
      default: out = '0;
    endcase

    // Compare flags relate the operands, not the result; the PSR mask decides who keeps them.
    if (op_legal(op)) begin
      flags[FLAG_Z] = (a == b);
      flags[FLAG_L] = (a < b);
      flags[FLAG_N] = ($signed(a) < $signed(b));
      if (op == OP_ADD) begin
        flags[FLAG_C] = sum[DATA_W];
        flags[FLAG_F] = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end else if (op == OP_SUB) begin
        flags[FLAG_F] = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state ALU sequencer with register file and PSR
// Define ALU_SEQ_DBG_EN to add the dbg_rd_addr/dbg_rd_data register file read port.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [3:0]        req_dst,
  input  logic [3:0]        req_src,
  input  logic              req_imm_sel,
  input  logic [DATA_W-1:0] req_imm,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic [4:0]        rsp_flags,
  output logic              rsp_err,
  output logic              busy
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [3:0]        dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data
`endif
);

  seq_state_t        state;
  logic [4:0]        op_q;
  logic [3:0]        dst_q;
  logic [3:0]        src_q;
  logic              imm_sel_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        flg_q;
  logic [4:0]        psr;
  logic [DATA_W-1:0] rf [RF_DEPTH];

  logic [DATA_W-1:0] alu_out;
  logic [4:0]        alu_flags;
  logic [4:0]        mask;

  alu_sequencer_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (opa_q),
    .b     (opb_q),
    .op    (op_q),
    .out   (alu_out),
    .flags (alu_flags)
  );

  assign mask      = psr_mask(op_q);
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_flags = psr;

`ifdef ALU_SEQ_DBG_EN
  assign dbg_rd_data = rf[dbg_rd_addr];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      dst_q      <= '0;
      src_q      <= '0;
      imm_sel_q  <= 1'b0;
      imm_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      flg_q      <= '0;
      psr        <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_result <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            dst_q     <= req_dst;
            src_q     <= req_src;
            imm_sel_q <= req_imm_sel;
            imm_q     <= req_imm;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          opa_q <= rf[dst_q];
          opb_q <= imm_sel_q ? imm_q : rf[src_q];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q <= alu_out;
          flg_q <= alu_flags;
          state <= ST_WB;
        end
        ST_WB: begin
          if (op_legal(op_q) && op_q != OP_CMP) rf[dst_q] <= res_q;
          psr        <= (psr & ~mask) | (flg_q & mask);
          rsp_valid  <= 1'b1;
          rsp_err    <= !op_legal(op_q);
          rsp_result <= op_legal(op_q) ? res_q : '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, CMP = 5'd2, AND_ = 5'd3, OR_ = 5'd4;
  localparam logic [4:0] XOR_ = 5'd5, NOT_ = 5'd6, LSH = 5'd7, RSH = 5'd8, ARSH = 5'd9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [3:0]  req_dst = '0;
  logic [3:0]  req_src = '0;
  logic        req_imm_sel = 1'b0;
  logic [15:0] req_imm = '0;
  logic        rsp_valid;
  logic [15:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_err;
  logic        busy;
`ifdef ALU_SEQ_DBG_EN
  logic [3:0]  dbg_rd_addr = '0;
  logic [15:0] dbg_rd_data;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_dst     (req_dst),
    .req_src     (req_src),
    .req_imm_sel (req_imm_sel),
    .req_imm     (req_imm),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_err     (rsp_err),
    .busy        (busy)
`ifdef ALU_SEQ_DBG_EN
    ,
    .dbg_rd_addr (dbg_rd_addr),
    .dbg_rd_data (dbg_rd_data)
`endif
  );

  // Issues one request from an IDLE cycle and returns the response and its latency in cycles.
  task automatic do_op(input logic [4:0] op, input logic [3:0] dst, input logic [3:0] src,
                       input logic isel, input logic [15:0] imm,
                       output logic [15:0] res, output logic [4:0] flg, output logic err,
                       output int lat);
    req_op = op; req_dst = dst; req_src = src; req_imm_sel = isel; req_imm = imm;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_imm = 16'hdead;
    lat = 99; res = 'x; flg = 'x; err = 1'bx;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; res = rsp_result; flg = rsp_flags; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] r; logic [4:0] f; logic e; int lat;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_flags !== 5'b00000) begin bad++; $display("FAIL reset_flags got=%b exp=00000", rsp_flags); end
    total++; if (rsp_result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h exp=0000", rsp_result); end
    do_op(OR_, 4'd15, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL reset_r15 got=%h exp=0000", r); end
  endtask

  task automatic test_add_sub();
    logic [15:0] r; logic [4:0] f; logic e; int lat;
    do_op(ADD, 4'd1, 4'd0, 1'b1, 16'h0005, r, f, e, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL add1_latency got=%0d exp=3", lat); end
    total++; if (r !== 16'h0005) begin bad++; $display("FAIL add1_result got=%h exp=0005", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL add1_err got=%b exp=0", e); end
    do_op(ADD, 4'd2, 4'd0, 1'b1, 16'h0003, r, f, e, lat);
    total++; if (r !== 16'h0003) begin bad++; $display("FAIL add2_result got=%h exp=0003", r); end
    do_op(SUB, 4'd1, 4'd2, 1'b0, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h0002) begin bad++; $display("FAIL sub_result got=%h exp=0002", r); end
    total++; if (f !== 5'b00000) begin bad++; $display("FAIL sub_flags got=%b exp=00000", f); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b exp=0", rsp_valid); end
    total++; if (rsp_result !== 16'h0002) begin bad++; $display("FAIL result_hold got=%h exp=0002", rsp_result); end
  endtask

  task automatic test_overflow();
    logic [15:0] r; logic [4:0] f; logic e; int lat;
    do_op(ADD, 4'd3, 4'd0, 1'b1, 16'h8000, r, f, e, lat);
    total++; if (f !== 5'b00010) begin bad++; $display("FAIL r3_init_flags got=%b exp=00010", f); end
    do_op(ADD, 4'd3, 4'd0, 1'b1, 16'hFFFF, r, f, e, lat);
    total++; if (r !== 16'h7FFF) begin bad++; $display("FAIL ovf_result got=%h exp=7fff", r); end
    total++; if (f !== 5'b10111) begin bad++; $display("FAIL ovf_flags got=%b exp=10111", f); end
    do_op(OR_, 4'd3, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h7FFF) begin bad++; $display("FAIL ovf_r3 got=%h exp=7fff", r); end
    total++; if (f !== 5'b10111) begin bad++; $display("FAIL or_keeps_psr got=%b exp=10111", f); end
  endtask

  task automatic test_cmp();
    logic [15:0] r; logic [4:0] f; logic e; int lat;
    do_op(AND_, 4'd1, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    do_op(OR_, 4'd1, 4'd0, 1'b1, 16'h0005, r, f, e, lat);
    total++; if (r !== 16'h0005) begin bad++; $display("FAIL cmp_setup got=%h exp=0005", r); end
    do_op(CMP, 4'd1, 4'd0, 1'b1, 16'h0005, r, f, e, lat);
    total++; if (f !== 5'b01101) begin bad++; $display("FAIL cmp_flags got=%b exp=01101", f); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL cmp_err got=%b exp=0", e); end
    do_op(OR_, 4'd1, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h0005) begin bad++; $display("FAIL cmp_no_write got=%h exp=0005", r); end
  endtask

  task automatic test_illegal();
    logic [15:0] r; logic [4:0] f; logic e; int lat;
    do_op(5'd15, 4'd1, 4'd3, 1'b1, 16'h1234, r, f, e, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL ill_latency got=%0d exp=3", lat); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", e); end
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL ill_result got=%h exp=0000", r); end
    total++; if (f !== 5'b01101) begin bad++; $display("FAIL ill_flags got=%b exp=01101", f); end
    do_op(5'd10, 4'd3, 4'd1, 1'b0, 16'h0000, r, f, e, lat);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL ill10_err got=%b exp=1", e); end
    do_op(OR_, 4'd1, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h0005) begin bad++; $display("FAIL ill_r1 got=%h exp=0005", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL ill_next_err got=%b exp=0", e); end
    do_op(OR_, 4'd3, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h7FFF) begin bad++; $display("FAIL ill_r3 got=%h exp=7fff", r); end
  endtask

  task automatic test_shift_logic();
    logic [15:0] r; logic [4:0] f; logic e; int lat;
    do_op(LSH, 4'd9, 4'd0, 1'b1, 16'h8001, r, f, e, lat);
    total++; if (r !== 16'h0002) begin bad++; $display("FAIL lsh got=%h exp=0002", r); end
    do_op(RSH, 4'd9, 4'd0, 1'b1, 16'h8002, r, f, e, lat);
    total++; if (r !== 16'h4001) begin bad++; $display("FAIL rsh got=%h exp=4001", r); end
    do_op(ARSH, 4'd9, 4'd0, 1'b1, 16'h8002, r, f, e, lat);
    total++; if (r !== 16'hC001) begin bad++; $display("FAIL arsh got=%h exp=c001", r); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL arsh_err got=%b exp=0", e); end
    do_op(NOT_, 4'd9, 4'd0, 1'b1, 16'h00FF, r, f, e, lat);
    total++; if (r !== 16'hFF00) begin bad++; $display("FAIL not got=%h exp=ff00", r); end
    do_op(XOR_, 4'd8, 4'd0, 1'b1, 16'h00F0, r, f, e, lat);
    total++; if (r !== 16'h00F0) begin bad++; $display("FAIL xor got=%h exp=00f0", r); end
    do_op(AND_, 4'd8, 4'd0, 1'b1, 16'h0030, r, f, e, lat);
    total++; if (r !== 16'h0030) begin bad++; $display("FAIL and got=%h exp=0030", r); end
    do_op(OR_, 4'd8, 4'd0, 1'b1, 16'h0101, r, f, e, lat);
    total++; if (r !== 16'h0131) begin bad++; $display("FAIL or got=%h exp=0131", r); end
    total++; if (f !== 5'b01101) begin bad++; $display("FAIL logic_psr got=%b exp=01101", f); end
  endtask

  task automatic test_dst_eq_src();
    logic [15:0] r; logic [4:0] f; logic e; int lat;
    do_op(ADD, 4'd6, 4'd0, 1'b1, 16'h0007, r, f, e, lat);
    do_op(ADD, 4'd6, 4'd6, 1'b0, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h000E) begin bad++; $display("FAIL same_add got=%h exp=000e", r); end
    do_op(SUB, 4'd6, 4'd6, 1'b0, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL same_sub got=%h exp=0000", r); end
    total++; if (f !== 5'b01000) begin bad++; $display("FAIL same_sub_flags got=%b exp=01000", f); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r; logic [4:0] f; logic e; int lat; int busy_bad;
    busy_bad = 0;
    req_op = ADD; req_dst = 4'd5; req_src = 4'd0; req_imm_sel = 1'b1; req_imm = 16'h0001;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_imm = 16'h0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) busy_bad++;
    end
    total++; if (busy_bad != 0) begin bad++; $display("FAIL busy_window got=%0d exp=0 bad cycles", busy_bad); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_result !== 16'h0001) begin bad++; $display("FAIL b2b_latched got=%h exp=0001", rsp_result); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
    req_valid = 1'b0;
    do_op(OR_, 4'd5, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
    total++; if (r !== 16'h0001) begin bad++; $display("FAIL b2b_r5 got=%h exp=0001", r); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] r; logic [4:0] f; logic e; int lat; int seen;
    seen = 0;
    req_op = ADD; req_dst = 4'd7; req_src = 4'd0; req_imm_sel = 1'b1; req_imm = 16'h0055;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1'b1;
    @(negedge clk);
    if (rsp_valid === 1'b1) seen++;
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b exp=0", busy); end
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_no_pulse got=%0d exp=0", seen); end
    do_op(OR_, 4'd7, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL mid_r7 got=%h exp=0000", r); end
    total++; if (f !== 5'b00000) begin bad++; $display("FAIL mid_psr got=%b exp=00000", f); end
    do_op(OR_, 4'd1, 4'd0, 1'b1, 16'h0000, r, f, e, lat);
    total++; if (r !== 16'h0000) begin bad++; $display("FAIL mid_r1 got=%h exp=0000", r); end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_overflow();
    test_cmp();
    test_illegal();
    test_shift_logic();
    test_dst_eq_src();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: DATA_W, 16, operand/result width; fixed at 16, other values unsupported.
REQ-002 Parameter: RF_DEPTH, 16, register file entries; address width 4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  sequencer can accept a request this cycle.
REQ-007 req_op  input  5  ALU opcode: ADD 0, SUB 1, CMP 2, AND 3, OR 4, XOR 5, NOT 6, LSH 7, RSH 8, ARSH 9.
REQ-008 req_dst  input  4  Rdest register index; also the writeback target.
REQ-009 req_src  input  4  Rsrc register index.
REQ-010 req_imm_sel  input  1  1: req_imm replaces the register-file Rsrc operand.
REQ-011 req_imm  input  16  immediate operand.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_result  output  16  ALU result of the completed operation.
REQ-014 rsp_flags  output  5  PSR after completion: bit0 C, bit1 L, bit2 F, bit3 Z, bit4 N.
REQ-015 rsp_err  output  1  qualifies rsp_valid; completed opcode was illegal.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 FSM states: IDLE, READ, EXEC, WB; IDLE->READ on req_valid&&req_ready; READ->EXEC, EXEC->WB, WB->IDLE unconditionally.
REQ-018 req_ready is 1 only in IDLE; requests offered outside IDLE are not accepted and have no effect.
REQ-019 On acceptance, op, dst, src, imm_sel and imm are latched; later input changes do not affect the operation.
REQ-020 READ: latch Rdest=RF[dst] and Rsrc=(imm_sel ? imm : RF[src]) into operand registers driving the ALU instance.
REQ-021 EXEC: capture the ALU Out and Flags into result/flag holding registers.
REQ-022 WB: write the result to RF[dst] for all legal opcodes except CMP, update the PSR, and pulse rsp_valid.
REQ-023 Latency: request accepted at edge T yields rsp_valid high in the cycle after edge T+3; maximum throughput one operation per 4 cycles.
REQ-024 ALU semantics: ADD Rdest+Rsrc, SUB Rdest-Rsrc, logic ops bitwise on Rdest and Rsrc, NOT/LSH/RSH/ARSH act on Rsrc by 1 bit; arithmetic wraps modulo 2^16.
REQ-025 PSR update mask: ADD/SUB update all five flags; CMP updates L, Z, N only, with C and F retained; logic and shift ops leave PSR unchanged.
REQ-026 Flag meaning: Z Rdest==Rsrc; L Rdest<Rsrc unsigned; N Rdest<Rsrc signed; C carry-out of ADD; F signed overflow of ADD/SUB.
REQ-027 Opcodes 10..31 are illegal: no RF write, PSR unchanged, rsp_result=0, rsp_err=1 with rsp_valid.
REQ-028 dst==src is legal; both operands read the same pre-writeback value.
REQ-029 rsp_result and rsp_flags hold their values until the next WB; rsp_valid and rsp_err are 0 outside WB.

Reset
REQ-030 reset has priority over all other inputs in any state: FSM->IDLE, all RF entries 0, PSR 0, operand/result registers 0, rsp_valid 0, rsp_err 0, rsp_result 0.
REQ-031 Reset mid-operation (READ/EXEC/WB) aborts the operation: no RF write and no rsp_valid pulse; req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-032 Macro ALU_SEQ_DBG_EN; when defined, adds ports dbg_rd_addr (input 4) and dbg_rd_data (output 16), giving combinational read of RF[dbg_rd_addr] that does not disturb the FSM.
REQ-033 Without ALU_SEQ_DBG_EN, the ports are absent and behaviour is otherwise identical.

Structure
REQ-034 Shared package holds opcode constants, flag bit indices (C=0, L=1, F=2, Z=3, N=4), the FSM state typedef, and per-opcode PSR update masks.
REQ-035 The existing ALU module is instantiated as the single sub-module; the register file and FSM are inline.

Verification
REQ-036 Reset released -> req_ready=1, busy=0, rsp_valid=0, rsp_flags=5'b00000; with DBG, RF r0..r15 read 0.
REQ-037 ADD dst1 imm 0x0005 at T -> rsp_valid at T+3, result 0x0005; ADD dst2 imm 0x0003; SUB dst1 src2 -> result 0x0002, Z=0.
REQ-038 r3=0x8000 via imm; ADD dst3 imm 0xFFFF -> result 0x7FFF, C=1, F=1; r3 becomes 0x7FFF.
REQ-039 r1=5; CMP dst1 imm 5 -> Z=1, L=0, N=0, C/F equal to prior values, r1 still 0x0005.
REQ-040 Opcode 5'd15 -> rsp_valid with rsp_err=1, rsp_result 0x0000, PSR and all RF entries unchanged.
REQ-041 reset pulsed while in EXEC -> next cycle IDLE, no rsp_valid pulse, dst register reads 0, req_ready=1.
